// File: rtl/audio_meter_pkg.sv
// audio_meter_pkg: shared types, mode codes and helpers for the level meter.
// Provides clog2, the sample magnitude function and the hold FSM state type.
package audio_meter_pkg;

  localparam logic MODE_RAW     = 1'b0;
  localparam logic MODE_CENTRED = 1'b1;

  // Magnitudes travel at this width; callers keep the low SAMPLE_W bits.
  localparam int MAG_W = 32;

  typedef enum logic [1:0] {
    TRACK,
    HOLD,
    DECAY
  } hold_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Centred mode folds around midscale and doubles, so a full swing either
  // way reaches full scale; the +2 headroom bits carry sign and doubling.
  function automatic logic [MAG_W-1:0] magnitude(
    input logic             md,
    input logic [MAG_W-1:0] smp,
    input int               w
  );
    logic signed [MAG_W+1:0] d;
    logic signed [MAG_W+1:0] a;
    logic signed [MAG_W+1:0] lim;
    lim = ((MAG_W+2)'(1) <<< w) - (MAG_W+2)'(1);
    d   = $signed({2'b00, smp}) - ((MAG_W+2)'(1) <<< (w - 1));
    a   = (d < 0) ? -d : d;
    a   = a <<< 1;
    if (a > lim) a = lim;
    if (md == MODE_RAW) return smp;
    return a[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/audio_level_quantiser.sv
// audio_level_quantiser: maps a peak magnitude onto 0..LEVELS.
// Ports: peak (SAMPLE_W) in, level (LVL_W) out; purely combinational.
module audio_level_quantiser
  import audio_meter_pkg::*;
#(
  parameter int SAMPLE_W = 12,
  parameter int LEVELS   = 9,
  parameter int LVL_W    = clog2(LEVELS + 1)
) (
  input  logic [SAMPLE_W-1:0] peak,
  output logic [LVL_W-1:0]    level
);

  localparam int QW = clog2(LEVELS + 2);
  localparam int PW = SAMPLE_W + QW;

  logic [PW-1:0] prod;
  logic [QW-1:0] q;
  logic          unused_frac;

  // Full-width product: LEVELS+1 < 2^QW, so nothing is lost before the shift.
  assign prod        = PW'(peak) * PW'(LEVELS + 1);
  assign q           = prod[PW-1:SAMPLE_W];
  assign unused_frac = ^prod[SAMPLE_W-1:0];

  assign level = (q > QW'(LEVELS)) ? LVL_W'(LEVELS) : q[LVL_W-1:0];

endmodule

// File: rtl/audio_level_meter.sv
// audio_level_meter: windowed peak meter with level, LED bar and peak hold.
// Ports: clock, reset_n, sample_valid, sample, mode in; level, bar,
// hold_level, bar_hold, window_peak, level_valid out.
module audio_level_meter
  import audio_meter_pkg::*;
#(
  parameter int SAMPLE_W     = 12,
  parameter int WINDOW       = 4000,
  parameter int LEVELS       = 9,
  parameter int HOLD_WINDOWS = 5,
  parameter int LVL_W        = clog2(LEVELS + 1)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                mode,
  output logic [LVL_W-1:0]    level,
  output logic [LEVELS-1:0]   bar,
  output logic [LVL_W-1:0]    hold_level,
  output logic [LEVELS-1:0]   bar_hold,
  output logic [SAMPLE_W-1:0] window_peak,
  output logic                level_valid
);

  localparam int CNT_W = clog2(WINDOW);
  localparam int HC_W  = clog2(HOLD_WINDOWS + 1);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(WINDOW - 1);
  localparam logic [HC_W-1:0]  HC_MAX = HC_W'(HOLD_WINDOWS - 1);

  logic                mode_q;
  logic [CNT_W-1:0]    sample_cnt;
  logic [SAMPLE_W-1:0] running_peak;
  logic                close_q;

  logic [MAG_W-1:0]    mag_full;
  logic [SAMPLE_W-1:0] mag;
  logic                unused_mag;
  logic                mode_chg;
  logic [CNT_W-1:0]    base_cnt;
  logic [SAMPLE_W-1:0] base_peak;
  logic [SAMPLE_W-1:0] peak_new;
  logic                closing;

  // The live mode input is used so a sample arriving with a mode change
  // is measured in the new mode and opens the fresh window.
  assign mag_full   = magnitude(mode, MAG_W'(sample), SAMPLE_W);
  assign mag        = mag_full[SAMPLE_W-1:0];
  assign unused_mag = ^mag_full[MAG_W-1:SAMPLE_W];

  assign mode_chg  = (mode != mode_q);
  assign base_cnt  = mode_chg ? '0 : sample_cnt;
  assign base_peak = mode_chg ? '0 : running_peak;
  assign peak_new  = (mag > base_peak) ? mag : base_peak;
  assign closing   = sample_valid && (base_cnt == LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q       <= MODE_RAW;
      sample_cnt   <= '0;
      running_peak <= '0;
      window_peak  <= '0;
      close_q      <= 1'b0;
    end else begin
      mode_q  <= mode;
      close_q <= closing;
      if (sample_valid) begin
        if (closing) begin
          sample_cnt   <= '0;
          running_peak <= '0;
          window_peak  <= peak_new;
        end else begin
          sample_cnt   <= base_cnt + 1'b1;
          running_peak <= peak_new;
        end
      end else if (mode_chg) begin
        sample_cnt   <= '0;
        running_peak <= '0;
      end
    end
  end

  logic [LVL_W-1:0] q_level;

  audio_level_quantiser #(
    .SAMPLE_W(SAMPLE_W),
    .LEVELS  (LEVELS),
    .LVL_W   (LVL_W)
  ) u_quant (
    .peak (window_peak),
    .level(q_level)
  );

  hold_state_e      state;
  hold_state_e      state_n;
  logic [LVL_W-1:0] hold_n;
  logic [HC_W-1:0]  hold_cnt;
  logic [HC_W-1:0]  hold_cnt_n;
  logic [LEVELS-1:0] bar_n;
  logic [LEVELS-1:0] bar_hold_n;

  // Decay only starts once the marker has sat for HOLD_WINDOWS windows;
  // since L < hold_level there, one step down never undershoots L.
  always_comb begin
    state_n    = state;
    hold_n     = hold_level;
    hold_cnt_n = hold_cnt;
    if (close_q) begin
      if (q_level >= hold_level) begin
        state_n    = TRACK;
        hold_n     = q_level;
        hold_cnt_n = '0;
      end else if (hold_cnt < HC_MAX) begin
        state_n    = HOLD;
        hold_cnt_n = hold_cnt + 1'b1;
      end else begin
        state_n = DECAY;
        hold_n  = hold_level - 1'b1;
      end
    end
  end

  always_comb begin
    bar_n = '0;
    for (int i = 0; i < LEVELS; i++) begin
      bar_n[i] = (i < int'(q_level));
    end
    bar_hold_n = bar_n;
    if (hold_n != '0) bar_hold_n[hold_n - 1'b1] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= TRACK;
      hold_level  <= '0;
      hold_cnt    <= '0;
      level       <= '0;
      bar         <= '0;
      bar_hold    <= '0;
      level_valid <= 1'b0;
    end else begin
      state       <= state_n;
      hold_level  <= hold_n;
      hold_cnt    <= hold_cnt_n;
      level_valid <= close_q;
      if (close_q) begin
        level    <= q_level;
        bar      <= bar_n;
        bar_hold <= bar_hold_n;
      end
    end
  end

endmodule

// File: tb/tb_audio_level_meter.sv
// tb_audio_level_meter: directed bench for audio_level_meter.
// dut_a uses default parameters, dut_b uses WINDOW=4.
module tb_audio_level_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst_a, sv_a, mode_a, lv_a;
  logic [11:0] smp_a, wpk_a;
  logic [3:0]  level_a, hold_a;
  logic [8:0]  bar_a, barh_a;

  logic        rst_b, sv_b, mode_b, lv_b;
  logic [11:0] smp_b, wpk_b;
  logic [3:0]  level_b, hold_b;
  logic [8:0]  bar_b, barh_b;

  audio_level_meter dut_a (
    .clock       (clk),
    .reset_n     (rst_a),
    .sample_valid(sv_a),
    .sample      (smp_a),
    .mode        (mode_a),
    .level       (level_a),
    .bar         (bar_a),
    .hold_level  (hold_a),
    .bar_hold    (barh_a),
    .window_peak (wpk_a),
    .level_valid (lv_a)
  );

  audio_level_meter #(.WINDOW(4)) dut_b (
    .clock       (clk),
    .reset_n     (rst_b),
    .sample_valid(sv_b),
    .sample      (smp_b),
    .mode        (mode_b),
    .level       (level_b),
    .bar         (bar_b),
    .hold_level  (hold_b),
    .bar_hold    (barh_b),
    .window_peak (wpk_b),
    .level_valid (lv_b)
  );

  int lv_cnt_a = 0;
  always @(negedge clk) if (lv_a === 1'b1) lv_cnt_a++;

  task automatic run_window_a(
    input string       nm,
    input logic [11:0] fill,
    input logic [11:0] pk,
    input int          pk_idx,
    input logic [11:0] e_pk,
    input logic [3:0]  e_lvl,
    input logic [8:0]  e_bar,
    input logic [3:0]  e_hold,
    input logic [8:0]  e_barh
  );
    int c0;
    c0 = lv_cnt_a;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      sv_a  = 1'b1;
      smp_a = (i == pk_idx) ? pk : fill;
    end
    @(negedge clk);
    sv_a = 1'b0;
    checks++;
    if (lv_a !== 1'b0 || lv_cnt_a != c0) begin
      errors++;
      $display("FAIL %s early_pulse lv=%b pulses=%0d exp 0", nm, lv_a, lv_cnt_a - c0);
    end
    checks++;
    if (wpk_a !== e_pk) begin
      errors++;
      $display("FAIL %s window_peak got %0d exp %0d", nm, wpk_a, e_pk);
    end
    @(negedge clk);
    checks++;
    if (lv_a !== 1'b1) begin
      errors++;
      $display("FAIL %s level_valid got %b exp 1", nm, lv_a);
    end
    checks++;
    if (level_a !== e_lvl || bar_a !== e_bar) begin
      errors++;
      $display("FAIL %s level/bar got %0d/%h exp %0d/%h", nm, level_a, bar_a, e_lvl, e_bar);
    end
    checks++;
    if (hold_a !== e_hold || barh_a !== e_barh) begin
      errors++;
      $display("FAIL %s hold/bar_hold got %0d/%h exp %0d/%h", nm, hold_a, barh_a, e_hold, e_barh);
    end
    @(negedge clk);
    checks++;
    if (lv_a !== 1'b0 || lv_cnt_a != c0 + 1) begin
      errors++;
      $display("FAIL %s pulse_width lv=%b pulses=%0d exp 1", nm, lv_a, lv_cnt_a - c0);
    end
  endtask

  task automatic run_window_b(
    input string       nm,
    input logic [11:0] s0, s1, s2, s3,
    input logic [11:0] e_pk,
    input logic [3:0]  e_lvl,
    input logic [8:0]  e_bar,
    input logic [3:0]  e_hold,
    input logic [8:0]  e_barh
  );
    logic [11:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sv_b  = 1'b1;
      smp_b = s[i];
    end
    @(negedge clk);
    sv_b = 1'b0;
    checks++;
    if (lv_b !== 1'b0 || wpk_b !== e_pk) begin
      errors++;
      $display("FAIL %s lv/peak got %b/%0d exp 0/%0d", nm, lv_b, wpk_b, e_pk);
    end
    @(negedge clk);
    checks++;
    if (lv_b !== 1'b1 || level_b !== e_lvl || bar_b !== e_bar) begin
      errors++;
      $display("FAIL %s lv/level/bar got %b/%0d/%h exp 1/%0d/%h", nm, lv_b, level_b, bar_b, e_lvl, e_bar);
    end
    checks++;
    if (hold_b !== e_hold || barh_b !== e_barh) begin
      errors++;
      $display("FAIL %s hold/bar_hold got %0d/%h exp %0d/%h", nm, hold_b, barh_b, e_hold, e_barh);
    end
  endtask

  // One sample every third cycle; returns one cycle after its possible close
  // edge, where level_valid would be high.
  task automatic b_sample(input logic [11:0] s, input logic m);
    @(negedge clk);
    sv_b   = 1'b1;
    smp_b  = s;
    mode_b = m;
    @(negedge clk);
    sv_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_a = 1'b0; sv_a = 1'b0; smp_a = '0; mode_a = 1'b0;
    rst_b = 1'b0; sv_b = 1'b0; smp_b = '0; mode_b = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (level_a !== 4'd0 || bar_a !== 9'h0 || lv_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_level got %0d/%h/%b exp 0/0/0", level_a, bar_a, lv_a);
    end
    checks++;
    if (hold_a !== 4'd0 || barh_a !== 9'h0 || wpk_a !== 12'd0) begin
      errors++;
      $display("FAIL reset_hold got %0d/%h/%0d exp 0/0/0", hold_a, barh_a, wpk_a);
    end
    checks++;
    if (level_b !== 4'd0 || hold_b !== 4'd0 || lv_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b got %0d/%0d/%b exp 0/0/0", level_b, hold_b, lv_b);
    end
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_raw_levels;
    mode_a = 1'b0;
    run_window_a("raw_zero", 12'd0, 12'd0, 0, 12'd0, 4'd0, 9'h000, 4'd0, 9'h000);
    run_window_a("raw_mid", 12'd100, 12'd2048, 3999, 12'd2048, 4'd5, 9'h01F, 4'd5, 9'h01F);
    run_window_a("raw_full", 12'd7, 12'd4095, 0, 12'd4095, 4'd9, 9'h1FF, 4'd9, 9'h1FF);
  endtask

  task automatic test_centred;
    @(negedge clk);
    mode_a = 1'b1;
    @(negedge clk);
    run_window_a("ctr_full", 12'd2048, 12'd0, 10, 12'd4095, 4'd9, 9'h1FF, 4'd9, 9'h1FF);
    run_window_a("ctr_3000", 12'd2048, 12'd3000, 3999, 12'd1904, 4'd4, 9'h00F, 4'd9, 9'h10F);
    run_window_a("ctr_mid", 12'd2048, 12'd2048, 0, 12'd0, 4'd0, 9'h000, 4'd9, 9'h100);
  endtask

  task automatic test_mode_toggle;
    int c0;
    c0 = lv_cnt_a;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      sv_a  = 1'b1;
      smp_a = 12'd4000;
    end
    @(negedge clk);
    sv_a   = 1'b0;
    mode_a = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (lv_cnt_a != c0) begin
      errors++;
      $display("FAIL toggle_no_pulse pulses got %0d exp 0", lv_cnt_a - c0);
    end
    run_window_a("toggle_win", 12'd100, 12'd1000, 5, 12'd1000, 4'd2, 9'h003, 4'd9, 9'h103);
  endtask

  task automatic test_gapped;
    logic [11:0] s [3];
    s[0] = 12'd10; s[1] = 12'd20; s[2] = 12'd30;
    for (int i = 0; i < 3; i++) begin
      b_sample(s[i], 1'b0);
      checks++;
      if (lv_b !== 1'b0) begin
        errors++;
        $display("FAIL gap_early sample %0d lv got %b exp 0", i, lv_b);
      end
    end
    b_sample(12'd4095, 1'b0);
    checks++;
    if (lv_b !== 1'b1 || level_b !== 4'd9 || wpk_b !== 12'd4095) begin
      errors++;
      $display("FAIL gap_close lv/level/peak got %b/%0d/%0d exp 1/9/4095", lv_b, level_b, wpk_b);
    end
    checks++;
    if (bar_b !== 9'h1FF || hold_b !== 4'd9) begin
      errors++;
      $display("FAIL gap_bar bar/hold got %h/%0d exp 1ff/9", bar_b, hold_b);
    end
    @(negedge clk);
    checks++;
    if (lv_b !== 1'b0) begin
      errors++;
      $display("FAIL gap_pulse lv got %b exp 0", lv_b);
    end
  endtask

  task automatic test_mode_same_cycle;
    b_sample(12'd4095, 1'b0);
    b_sample(12'd4095, 1'b0);
    for (int i = 0; i < 3; i++) begin
      b_sample(12'd2048, 1'b1);
      checks++;
      if (lv_b !== 1'b0) begin
        errors++;
        $display("FAIL same_cycle_early sample %0d lv got %b exp 0", i, lv_b);
      end
    end
    b_sample(12'd2048, 1'b1);
    checks++;
    if (lv_b !== 1'b1 || level_b !== 4'd0 || wpk_b !== 12'd0) begin
      errors++;
      $display("FAIL same_cycle_close lv/level/peak got %b/%0d/%0d exp 1/0/0", lv_b, level_b, wpk_b);
    end
    checks++;
    if (hold_b !== 4'd9 || barh_b !== 9'h100) begin
      errors++;
      $display("FAIL same_cycle_hold got %0d/%h exp 9/100", hold_b, barh_b);
    end
  endtask

  task automatic test_peak_hold;
    logic [3:0] eh  [12];
    logic [8:0] ebh [12];
    eh  = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd2};
    ebh = '{9'h103, 9'h103, 9'h103, 9'h103, 9'h083, 9'h043,
            9'h023, 9'h013, 9'h00B, 9'h007, 9'h003, 9'h003};
    @(negedge clk);
    rst_b  = 1'b0;
    mode_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    run_window_b("hold_top", 12'd4095, 12'd0, 12'd0, 12'd0, 12'd4095, 4'd9, 9'h1FF, 4'd9, 9'h1FF);
    for (int k = 0; k < 12; k++) begin
      run_window_b($sformatf("hold_w%0d", k), 12'd0, 12'd1000, 12'd0, 12'd0,
                   12'd1000, 4'd2, 9'h003, eh[k], ebh[k]);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      sv_a  = 1'b1;
      smp_a = 12'd4095;
    end
    @(negedge clk);
    sv_a = 1'b0;
    checks++;
    if (hold_a !== 4'd9 || level_a !== 4'd2) begin
      errors++;
      $display("FAIL pre_reset hold/level got %0d/%0d exp 9/2", hold_a, level_a);
    end
    rst_a = 1'b0;
    #1;
    checks++;
    if (level_a !== 4'd0 || bar_a !== 9'h0 || hold_a !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset level/bar/hold got %0d/%h/%0d exp 0/0/0", level_a, bar_a, hold_a);
    end
    checks++;
    if (barh_a !== 9'h0 || wpk_a !== 12'd0 || lv_a !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset barh/peak/lv got %h/%0d/%b exp 0/0/0", barh_a, wpk_a, lv_a);
    end
    @(negedge clk);
    rst_a = 1'b1;
    run_window_a("post_reset", 12'd0, 12'd2048, 17, 12'd2048, 4'd5, 9'h01F, 4'd5, 9'h01F);

    b_sample(12'd4095, 1'b0);
    b_sample(12'd4095, 1'b0);
    rst_b = 1'b0;
    #1;
    checks++;
    if (level_b !== 4'd0 || hold_b !== 4'd0 || barh_b !== 9'h0 || wpk_b !== 12'd0) begin
      errors++;
      $display("FAIL b_reset got %0d/%0d/%h/%0d exp 0/0/0/0", level_b, hold_b, barh_b, wpk_b);
    end
    @(negedge clk);
    rst_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_sample(12'd0, 1'b0);
      checks++;
      if (lv_b !== 1'b0) begin
        errors++;
        $display("FAIL b_post_reset_early sample %0d lv got %b exp 0", i, lv_b);
      end
    end
    b_sample(12'd4095, 1'b0);
    checks++;
    if (lv_b !== 1'b1 || level_b !== 4'd9 || hold_b !== 4'd9) begin
      errors++;
      $display("FAIL b_post_reset_close got %b/%0d/%0d exp 1/9/9", lv_b, level_b, hold_b);
    end
  endtask

  initial begin
    test_reset;
    test_raw_levels;
    test_centred;
    test_mode_toggle;
    test_gapped;
    test_mode_same_cycle;
    test_peak_hold;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_level_meter.md
# audio_level_meter

Parametrised windowed peak meter for the microphone path. It accepts strobed ADC samples and tracks the peak magnitude over a fixed-length sample window. At each window close it publishes a quantised volume level, a thermometer LED bar and a decaying peak-hold marker. It sits between the MIC sampling front end and the LED/7-segment display logic, and replaces the fixed 12-bit/9-LED volume meter.

## Interface
Parameters:
- SAMPLE_W, 12, ADC sample width (unsigned, offset-binary)
- WINDOW, 4000, accepted samples per measurement window (≥2)
- LEVELS, 9, number of bar LEDs; level range 0..LEVELS
- HOLD_WINDOWS, 5, windows the peak-hold marker stays before decaying
- LVL_W, $clog2(LEVELS+1), level output width

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- sample_valid  in  1  one-cycle strobe, sample is taken when high
- sample  in  SAMPLE_W  raw ADC code
- mode  in  1  0 = raw code is the magnitude; 1 = centred magnitude around midscale
- level  out  LVL_W  quantised level of last closed window
- bar  out  LEVELS  thermometer, bar[i] = (i < level)
- hold_level  out  LVL_W  peak-hold level
- bar_hold  out  LEVELS  bar OR one-hot marker at bit hold_level-1 (no marker when hold_level = 0)
- window_peak  out  SAMPLE_W  peak magnitude of last closed window
- level_valid  out  1  one-cycle pulse when level/bar/hold update

## Operation
- Magnitude:
  - mode 0: mag = sample.
  - mode 1: d = sample − 2^(SAMPLE_W−1); mag = min(2·|d|, 2^SAMPLE_W−1). Arithmetic is at SAMPLE_W+2 bits signed, with saturation.
- Accumulation: on each accepted sample, running_peak ← max(running_peak, mag) and sample_cnt increments.
- Window close: the accepted sample with sample_cnt = WINDOW−1 closes the window.
  - The peak used is max(running_peak, mag of that sample), so the closing sample is included.
  - running_peak and sample_cnt clear. The next sample starts a new window.
  - A window is exactly WINDOW samples.
- Quantisation: level = min((peak·(LEVELS+1)) >> SAMPLE_W, LEVELS). The product is at SAMPLE_W+$clog2(LEVELS+2) bits, with no truncation before the shift.
- Peak-hold, evaluated once per window close with the new level L:
  - If L ≥ hold_level: hold_level ← L and hold_cnt ← 0.
  - Else if hold_cnt < HOLD_WINDOWS−1: hold_cnt increments.
  - Else: hold_level ← hold_level−1 (never below L); hold_cnt stays saturated.
- Mode change: mode is registered. A change of the registered mode clears running_peak and sample_cnt, which discards the partial window. hold_level and the outputs are kept.
  - If a sample is accepted in the same cycle as a mode change, the sample belongs to the new window and uses the new mode.

## Timing
- Sample accepted at edge E (the sample_valid=1 cycle):
  - running_peak updates at E.
  - If the sample closes the window, window_peak is registered at E.
  - level, bar, hold_level, bar_hold and level_valid are registered at E+1.
  - level_valid is high for exactly cycle E+1 → E+2.
- Consecutive sample_valid cycles are allowed at full rate. With WINDOW ≥ 2, level_valid pulses never overlap.
- Idle cycles (sample_valid=0) change nothing except the mode-change clear.
- Reset (any time, including mid-window):
  - All state and outputs go to 0: level, bar, hold_level, bar_hold, window_peak, level_valid, running_peak, sample_cnt, hold_cnt.
  - The registered mode resets to 0.
  - The first window after reset release starts at the first accepted sample.
- Full scale: mag = 2^SAMPLE_W−1 gives level = LEVELS and an all-ones bar. mag = 0 gives level 0 and an empty bar.

## Structure
- Shared package audio_meter_pkg holds:
  - the MODE_RAW and MODE_CENTRED constants
  - the clog2 helper
  - the magnitude function (mode, sample → mag)
- Sub-module audio_level_quantiser: combinational peak → level, with parameters SAMPLE_W, LEVELS and LVL_W. It is reused by the 7-segment digit logic.
- Top level holds the sample counter, running peak, hold FSM (states TRACK, HOLD, DECAY) and output registers.

## Test plan
- Defaults, mode 0. Windows of 4000 samples with max 0, 2048 and 4095 → level 0 then 5 then 9; bar 0x000, 0x01F, 0x1FF. level_valid pulses once per window, one cycle after the 4000th sample.
- Mode 1, window containing samples 2048 and 0 → mag 4095, level 9. A window of all 2048 → level 0.
- Peak-hold with HOLD_WINDOWS=5. Level 9 window, then level-2 windows → hold_level stays 9 for 4 windows, then 8, 7, … one per window down to 2. bar_hold = bar | (1<<(hold_level−1)).
- Gapped strobes: sample_valid every 3rd cycle, WINDOW=4 → close after exactly 4 accepted samples. The peak on the 4th sample is included.
- Mode toggled after 1000 samples of peak 4000 → that partial window is discarded. The next level_valid comes after 4000 further samples and reflects only post-toggle samples.
- reset_n asserted mid-window and mid-hold → all outputs 0 immediately. After release, the first level_valid comes after exactly WINDOW samples.
